// File: rtl/rvfi_trace_buffer.sv
// RVFI retirement trace buffer: stamps each retired instruction with a sequence
// number and queues it in a first-word-fall-through FIFO. Never stalls the core.
module rvfi_trace_buffer #(
   parameter int DEPTH  = 16,
   parameter int SEQ_W  = 16,
   parameter int DROP_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       enable,
   input  logic                       clear,
   input  logic                       rvfi_valid,
   input  logic [31:0]                rvfi_pc_rdata,
   input  logic [31:0]                rvfi_insn,
   input  logic [4:0]                 rvfi_rd_addr,
   input  logic [31:0]                rvfi_rd_wdata,
   output logic                       trace_valid,
   input  logic                       trace_ready,
   output logic [31:0]                trace_pc,
   output logic [31:0]                trace_insn,
   output logic [4:0]                 trace_rd_addr,
   output logic [31:0]                trace_rd_wdata,
   output logic [SEQ_W-1:0]           trace_seq,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   output logic [DROP_W-1:0]          drop_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int REC_W = 32 + 32 + 5 + 32 + SEQ_W;
   localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

   logic [REC_W-1:0]  mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]  level_q, level_d;
   logic [SEQ_W-1:0]  seq_q, seq_d;
   logic              overflow_q, overflow_d;
   logic [DROP_W-1:0] drop_q, drop_d;

   logic              capture, pop, push, drop, full;
   logic [31:0]       wdata_in;
   logic [REC_W-1:0]  rec_in, head;

   assign capture = rvfi_valid & enable;
   assign full    = (level_q == FULL_LVL);
   assign pop     = trace_valid & trace_ready;
   // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
   assign push    = capture & (~full | pop);
   assign drop    = capture & full & ~pop;

   assign wdata_in = (rvfi_rd_addr == 5'd0) ? 32'd0 : rvfi_rd_wdata;
   assign rec_in   = {rvfi_pc_rdata, rvfi_insn, rvfi_rd_addr, wdata_in, seq_q};

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      seq_d      = seq_q;
      overflow_d = overflow_q;
      drop_d     = drop_q;

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase

      // Sequence advances on every capture, stored or dropped, so gaps reveal drops.
      if (capture) seq_d = seq_q + SEQ_W'(1);

      if (clear) begin
         overflow_d = 1'b0;
         drop_d     = '0;
      end else if (drop) begin
         overflow_d = 1'b1;
         if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         seq_q      <= '0;
         overflow_q <= 1'b0;
         drop_q     <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         seq_q      <= seq_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) mem_q[wr_ptr_q] <= rec_in;
   end

   assign head        = mem_q[rd_ptr_q];
   assign trace_valid = (level_q != '0);
   // Record fields read as zero while empty so stale entries never leak out.
   assign {trace_pc, trace_insn, trace_rd_addr, trace_rd_wdata, trace_seq} =
          trace_valid ? head : '0;

   assign level      = level_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_q;

endmodule

// File: doc/rvfi_trace_buffer.md
Name: rvfi_trace_buffer

Overview:
- Downstream consumer of the core wrapper's RVFI retirement port.
- Captures each retired-instruction record (pc, insn, rd_addr, rd_wdata) into a synchronous FIFO and tags it with a sequence number.
- Presents records on a valid/ready stream to the trace logger or scoreboard.
- Never back-pressures the core: it drops records when full and counts the drops.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 2.
- SEQ_W, 16, sequence-number width.
- DROP_W, 16, drop-counter width.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  capture enable; when 0, rvfi_valid is ignored (no push, no seq increment).
- clear  input  1  one-cycle pulse; clears overflow and drop_count only.
- rvfi_valid  input  1  retirement strobe from core.
- rvfi_pc_rdata  input  32  retired PC.
- rvfi_insn  input  32  retired instruction word.
- rvfi_rd_addr  input  5  destination register.
- rvfi_rd_wdata  input  32  destination write data.
- trace_valid  output  1  head record available.
- trace_ready  input  1  consumer accepts head.
- trace_pc  output  32  head PC.
- trace_insn  output  32  head instruction.
- trace_rd_addr  output  5  head rd.
- trace_rd_wdata  output  32  head rd data.
- trace_seq  output  SEQ_W  head sequence number.
- level  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky; set when any record is dropped.
- drop_count  output  DROP_W  number of dropped records, saturating.

Behaviour:
- Reset: all outputs, pointers, level, seq counter, overflow and drop_count go to 0. trace_valid=0. Record data outputs are 0 while empty. Reset wins over every simultaneous event.
- Capture event: rvfi_valid && enable.
  - Every capture event assigns the current seq value, then seq increments mod 2^SEQ_W (0xFFFF->0x0000), whether the record is stored or dropped. Gaps in trace_seq expose drops.
- x0 rule: if rvfi_rd_addr==0, the stored rd_wdata is forced to 0.
- Pop: trace_valid && trace_ready.
- Push: capture event && (level<DEPTH || pop in the same cycle).
  - Full with a simultaneous pop: push is accepted and level is unchanged.
- Drop: capture event && level==DEPTH && !pop.
  - On drop: overflow<=1; drop_count increments, saturating at all-ones.
  - FIFO contents and pointers are untouched.
- Stream: first-word-fall-through, with trace_valid = (level!=0).
  - Head fields stay stable while trace_valid && !trace_ready.
  - Latency: record captured at edge N is visible on trace_* after edge N (cycle N+1) when the FIFO was empty. No combinational path from rvfi_* to trace_*.
- Push and pop on an empty FIFO in the same cycle: the pop is not possible (trace_valid=0), so the push lands and level becomes 1.
- Pointers: log2(DEPTH) bits, wrapping naturally. Level updates are +1 on push only, -1 on pop only, unchanged on both or neither.
- clear:
  - Next cycle: overflow=0, drop_count=0.
  - If clear coincides with a drop: clear wins, so overflow=0 and drop_count=0.
  - Does not affect FIFO contents or seq.
- enable deassert mid-stream: already-buffered records remain poppable; only new captures stop.

Test Plan (DEPTH=4 unless stated):
- Reset, then rvfi_valid one cycle with pc=0x80000000, insn=0x00500093, rd=1, wdata=5 -> next cycle trace_valid=1, trace_seq=0, fields match, level=1; trace_ready=1 -> level=0, trace_valid=0.
- rd_addr=0, wdata=0xDEADBEEF captured -> trace_rd_wdata=0.
- trace_ready=0, 6 back-to-back captures -> level=4, drop_count=2, overflow=1. Drain yields seq 0,1,2,3. Next capture is stored with seq=6.
- Full FIFO with trace_ready=1 and capture in the same cycle -> no drop, level stays 4, new record appears at tail in order.
- Preload seq near wrap (capture 0xFFFF events with an always-ready consumer) -> records tagged 0xFFFF then 0x0000. Force 2^DROP_W+3 drops -> drop_count holds at 0xFFFF. Pulse clear -> overflow=0, drop_count=0, level unchanged.
- Mid-operation rst with level=3 -> next cycle level=0, trace_valid=0, overflow=0. Next capture gets seq=0.
